// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet frame sequencer.
//   state_t          one-hot encoding of the six sequencer states
//   RESULT_TAG       upper nibble of a successful result byte
//   ERR_TIMEOUT_BYTE byte returned to the host when inference times out
//   IMG_BYTES        size of one received image frame
package lenet_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_LOAD    = 6'b000010,
    ST_RELEASE = 6'b000100,
    ST_START   = 6'b001000,
    ST_RUN     = 6'b010000,
    ST_SEND    = 6'b100000
  } state_t;

  localparam logic [3:0] RESULT_TAG       = 4'hA;
  localparam logic [7:0] ERR_TIMEOUT_BYTE = 8'hEE;
  localparam int         IMG_BYTES        = 1764;

  function automatic logic [7:0] result_byte(input logic [3:0] cls);
    return {RESULT_TAG, cls};
  endfunction

endpackage

// File: rtl/lenet_frame_ctrl_watchdog.sv
// Inference watchdog: up-counter cleared by clr, advanced by inc.
//   clk, rst  clock, asynchronous active-high reset
//   clr       force count to zero (takes priority over inc)
//   inc       advance count by one
//   expire    count has reached TIMEOUT_CYC-1
// The count saturates at its terminal value so a stalled core cannot wrap
// the counter back into a non-expired range.
module lenet_watchdog #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  import lenet_pkg::*;

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/lenet_frame_ctrl.sv
// Sequencer between the UART frame receiver and the LeNet-5 core.
//   clk, rst       clock, asynchronous active-high reset
//   en             accept new frames (checked only in IDLE)
//   rx_finish      receiver holds a complete frame (level)
//   rx_later_read  pulse: receiver clears its image and finish flag
//   img_load       pulse: core captures the receiver image
//   cnn_start      pulse: begin inference
//   cnn_done       pulse from core, cnn_class valid with it
//   tx_valid/tx_data/tx_ready  result byte handshake to UART TX
//   busy           not in IDLE
//   err_timeout    sticky watchdog expiry flag
//   frame_cnt      count of successfully classified frames (wraps)
//
// state   | meaning
// IDLE    | wait for en & rx_finish
// LOAD    | img_load high, core samples image
// RELEASE | rx_later_read high, receiver clears image
// START   | cnn_start high, watchdog cleared
// RUN     | wait for cnn_done or watchdog expiry
// SEND    | hold result byte until accepted
module lenet_frame_ctrl #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CLASS_W     = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               rx_finish,
  output logic               rx_later_read,
  output logic               img_load,
  output logic               cnn_start,
  input  logic               cnn_done,
  input  logic [CLASS_W-1:0] cnn_class,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               busy,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   frame_cnt
);
  import lenet_pkg::*;

  state_t     state;
  logic       wd_expire;
  logic [3:0] cls4;

  assign cls4 = 4'(cnn_class);

  lenet_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_START),
    .inc    (state == ST_RUN),
    .expire (wd_expire)
  );

  // Each pulse output is set on the transition into its state and cleared
  // on the way out, so it is high exactly for the one cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rx_later_read <= 1'b0;
      img_load      <= 1'b0;
      cnn_start     <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && rx_finish) begin
            state    <= ST_LOAD;
            img_load <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          state         <= ST_RELEASE;
          img_load      <= 1'b0;
          rx_later_read <= 1'b1;
        end
        ST_RELEASE: begin
          state         <= ST_START;
          rx_later_read <= 1'b0;
          cnn_start     <= 1'b1;
        end
        ST_START: begin
          state     <= ST_RUN;
          cnn_start <= 1'b0;
        end
        ST_RUN: begin
          // done is tested first so a result in the expiry cycle still counts
          if (cnn_done) begin
            state     <= ST_SEND;
            tx_valid  <= 1'b1;
            tx_data   <= result_byte(cls4);
            frame_cnt <= frame_cnt + CNT_W'(1);
          end else if (wd_expire) begin
            state       <= ST_SEND;
            tx_valid    <= 1'b1;
            tx_data     <= ERR_TIMEOUT_BYTE;
            err_timeout <= 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          rx_later_read <= 1'b0;
          img_load      <= 1'b0;
          cnn_start     <= 1'b0;
          tx_valid      <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_frame_ctrl.sv
module tb_lenet_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx_finish;
  logic       rx_later_read;
  logic       img_load;
  logic       cnn_start;
  logic       cnn_done;
  logic [3:0] cnn_class;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       err_timeout;
  logic [1:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  lenet_frame_ctrl #(.TIMEOUT_CYC(64), .CLASS_W(4), .CNT_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .rx_finish     (rx_finish),
    .rx_later_read (rx_later_read),
    .img_load      (img_load),
    .cnn_start     (cnn_start),
    .cnn_done      (cnn_done),
    .cnn_class     (cnn_class),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},   rx_later_read, 0);
    chk({tag, "_img"},  img_load, 0);
    chk({tag, "_st"},   cnn_start, 0);
    chk({tag, "_txv"},  tx_valid, 0);
    chk({tag, "_txd"},  tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"},  err_timeout, 0);
    chk({tag, "_cnt"},  frame_cnt, 0);
  endtask

  // From IDLE with a frame present: LOAD, RELEASE, START, then first RUN cycle.
  // The bench plays the receiver and drops rx_finish once later_read is seen.
  task automatic start_frame(input string tag);
    rx_finish = 1'b1;
    tick();
    chk({tag, "_load_img"}, img_load, 1);
    chk({tag, "_load_rd"},  rx_later_read, 0);
    chk({tag, "_load_st"},  cnn_start, 0);
    chk({tag, "_load_busy"}, busy, 1);
    tick();
    chk({tag, "_rel_img"}, img_load, 0);
    chk({tag, "_rel_rd"},  rx_later_read, 1);
    chk({tag, "_rel_st"},  cnn_start, 0);
    rx_finish = 1'b0;
    tick();
    chk({tag, "_start_rd"}, rx_later_read, 0);
    chk({tag, "_start_st"}, cnn_start, 1);
    tick();
    chk({tag, "_run_st"},  cnn_start, 0);
    chk({tag, "_run_txv"}, tx_valid, 0);
  endtask

  // Wait n RUN cycles, then pulse cnn_done; check the latched result.
  task automatic finish_frame(input string tag, input int n, input logic [3:0] cls,
                              input logic [7:0] exp_byte, input logic [1:0] exp_cnt);
    for (int i = 0; i < n; i++) tick();
    chk({tag, "_pre_txv"}, tx_valid, 0);
    cnn_done  = 1'b1;
    cnn_class = cls;
    tick();
    cnn_done  = 1'b0;
    cnn_class = 4'h0;
    chk({tag, "_txv"},  tx_valid, 1);
    chk({tag, "_txd"},  tx_data, exp_byte);
    chk({tag, "_cnt"},  frame_cnt, exp_cnt);
    chk({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rx_finish = 1'b0; cnn_done = 1'b0;
    cnn_class = 4'h0; tx_ready = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    // 1: basic frame, class 7, receiver ready
    start_frame("t1");
    finish_frame("t1", 29, 4'd7, 8'hA7, 2'd1);
    tick();
    chk("t1_done_txv", tx_valid, 0);
    chk("t1_done_busy", busy, 0);

    // 2: back-pressure for 50 cycles
    tx_ready = 1'b0;
    start_frame("t2");
    finish_frame("t2", 10, 4'd7, 8'hA7, 2'd2);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t2_hold_txv", tx_valid, 1);
      chk("t2_hold_txd", tx_data, 8'hA7);
      chk("t2_hold_busy", busy, 1);
    end
    tx_ready = 1'b1;
    tick();
    chk("t2_xfer_txv", tx_valid, 0);
    chk("t2_xfer_busy", busy, 0);
    chk("t2_xfer_cnt", frame_cnt, 2);

    // 3: timeout, expiry on the 64th RUN cycle; late done ignored
    tx_ready = 1'b0;
    start_frame("t3");
    for (int i = 0; i < 63; i++) tick();
    chk("t3_pre_txv", tx_valid, 0);
    chk("t3_pre_err", err_timeout, 0);
    tick();
    chk("t3_to_txv", tx_valid, 1);
    chk("t3_to_txd", tx_data, 8'hEE);
    chk("t3_to_err", err_timeout, 1);
    chk("t3_to_cnt", frame_cnt, 2);
    for (int i = 0; i < 5; i++) tick();
    cnn_done = 1'b1; cnn_class = 4'd3;
    tick();
    cnn_done = 1'b0; cnn_class = 4'd0;
    chk("t3_late_txd", tx_data, 8'hEE);
    chk("t3_late_cnt", frame_cnt, 2);
    tx_ready = 1'b1;
    tick();
    chk("t3_xfer_busy", busy, 0);
    cnn_done = 1'b1; cnn_class = 4'd4;
    tick();
    cnn_done = 1'b0; cnn_class = 4'd0;
    chk("t3_idle_cnt", frame_cnt, 2);
    chk("t3_idle_txv", tx_valid, 0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_sticky_err", err_timeout, 1);

    // 4: next frame arrives during RUN, serviced after SEND; cnt wraps 3->0
    start_frame("t4a");
    rx_finish = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_pend_rd", rx_later_read, 0);
      chk("t4_pend_img", img_load, 0);
    end
    finish_frame("t4a", 0, 4'd2, 8'hA2, 2'd3);
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_img", img_load, 0);
    start_frame("t4b");
    finish_frame("t4b", 3, 4'd9, 8'hA9, 2'd0);
    tick();
    chk("t4b_xfer_busy", busy, 0);

    // 5: asynchronous reset in the middle of RUN with a frame held
    start_frame("t5");
    rx_finish = 1'b1;
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    tick();
    rst = 1'b0;
    start_frame("t5r");
    finish_frame("t5r", 7, 4'd0, 8'hA0, 2'd1);
    tick();

    // 6: en low parks in IDLE; en dropping mid-frame has no effect
    en = 1'b0;
    rx_finish = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_park_img", img_load, 0);
      chk("t6_park_busy", busy, 0);
    end
    en = 1'b1;
    start_frame("t6");
    en = 1'b0;
    finish_frame("t6", 5, 4'd5, 8'hA5, 2'd2);
    tick();
    chk("t6_xfer_busy", busy, 0);
    chk("t6_err", err_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
